// File: rtl/btb_update_queue.sv
// In-order FIFO buffering resolved-branch BTB updates from two execute ports onto one BTB write port.
// Optional BTB_UPD_COALESCE_EN: a push hitting a pending (non-popping) entry's BTB index rewrites it in place.
module btb_update_queue #(
  parameter int XLEN        = 32,
  parameter int BTB_ADDRESS = 6,
  parameter int DEPTH       = 4
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in0_valid,
  output logic                       in0_ready,
  input  logic [XLEN-1:0]            in0_pc,
  input  logic [XLEN-1:0]            in0_target,
  input  logic                       in0_is_ret,
  input  logic                       in1_valid,
  output logic                       in1_ready,
  input  logic [XLEN-1:0]            in1_pc,
  input  logic [XLEN-1:0]            in1_target,
  input  logic                       in1_is_ret,
  output logic                       update_btb,
  output logic [XLEN-1:0]            ex_pc,
  output logic [XLEN-1:0]            actual_target_address,
  output logic                       ex_is_ret,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]  pc_mem  [DEPTH];
  logic [XLEN-1:0]  tgt_mem [DEPTH];
  logic [DEPTH-1:0] ret_mem;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic             push0, push1, pop;
  logic             alloc0, alloc1;
  logic [PTR_W-1:0] slot0, slot1;

  // Readiness looks only at the registered count, never at the valids.
  assign in0_ready = count < CNT_W'(DEPTH);
  assign in1_ready = count < CNT_W'(DEPTH-1);
  assign push0     = in0_valid && in0_ready;
  assign push1     = in1_valid && in1_ready;
  assign pop       = count != '0;
  assign occupancy = count;

  assign update_btb            = pop;
  assign ex_pc                 = pop ? pc_mem[head]  : '0;
  assign actual_target_address = pop ? tgt_mem[head] : '0;
  assign ex_is_ret             = pop && ret_mem[head];

`ifdef BTB_UPD_COALESCE_EN
  logic [PTR_W-1:0] off [DEPTH];
  logic             match0, match1, same01;
  logic [PTR_W-1:0] hit0, hit1;

  // The head always pops when present, so only entries behind it are coalescing candidates.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    match0 = 1'b0;
    match1 = 1'b0;
    hit0   = '0;
    hit1   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off[i] = PTR_W'(i) - head;
      if (off[i] != '0 && CNT_W'(off[i]) < count) begin
        if (pc_mem[i][BTB_ADDRESS+1:2] == in0_pc[BTB_ADDRESS+1:2]) begin
          match0 = 1'b1;
          hit0   = PTR_W'(i);
        end
        if (pc_mem[i][BTB_ADDRESS+1:2] == in1_pc[BTB_ADDRESS+1:2]) begin
          match1 = 1'b1;
          hit1   = PTR_W'(i);
        end
      end
    end
  end

  assign same01 = push0 && (in0_pc[BTB_ADDRESS+1:2] == in1_pc[BTB_ADDRESS+1:2]);
  assign alloc0 = push0 && !match0;
  assign slot0  = match0 ? hit0 : tail;
  assign alloc1 = push1 && !match1 && !same01;
  assign slot1  = match1 ? hit1 : (same01 ? slot0 : tail + PTR_W'(alloc0));
`else
  assign alloc0 = push0;
  assign alloc1 = push1;
  assign slot0  = tail;
  assign slot1  = tail + PTR_W'(push0);
`endif

  always_ff @(posedge CLK) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(alloc0) + PTR_W'(alloc1);
      count <= count + CNT_W'(alloc0) + CNT_W'(alloc1) - CNT_W'(pop);
    end
  end

  // NOTE: the payload array has no reset; the count alone says which slots hold live data.
  always_ff @(posedge CLK) begin
    if (!reset && !flush) begin
      if (push0) begin
        pc_mem[slot0]  <= in0_pc;
        tgt_mem[slot0] <= in0_target;
        ret_mem[slot0] <= in0_is_ret;
      end
      // in1 is younger: on a shared slot its write lands last and wins.
      if (push1) begin
        pc_mem[slot1]  <= in1_pc;
        tgt_mem[slot1] <= in1_target;
        ret_mem[slot1] <= in1_is_ret;
      end
    end
  end

endmodule
